// File: rtl/i2s_rx_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg -- shared types and constants for the I2S capture path.
//   SAMPLE_W    : default audio sample width in bits
//   i2s_state_t : receiver FSM states
//   sample_t    : one audio sample at the default width
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } i2s_state_t;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_rx_if -- sample output bus from the I2S receiver to the downstream
// digital_delay D_In path.
//   L_Out        : last complete left sample, two's complement
//   R_Out        : last complete right sample, two's complement
//   Sample_Valid : one-Clk pulse when a new L/R pair is presented
//   Frame_Err    : one-Clk pulse on a short (truncated) word
// Modports: master = receiver (drives), slave = consumer (samples).
// ---------------------------------------------------------------------------
interface i2s_rx_if #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);

    logic [SAMPLE_W-1:0] L_Out;
    logic [SAMPLE_W-1:0] R_Out;
    logic                Sample_Valid;
    logic                Frame_Err;

    modport master (
        output L_Out,
        output R_Out,
        output Sample_Valid,
        output Frame_Err
    );

    modport slave (
        input L_Out,
        input R_Out,
        input Sample_Valid,
        input Frame_Err
    );

endinterface

// File: rtl/i2s_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge -- multi-flop synchronizer for one asynchronous input plus a
// change detector against the value held at the previous sample point.
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   din       : asynchronous input
//   sample_en : history register updates (and change is flagged) only here
//   level     : synchronized value of din
//   change    : level differs from the last sampled value (sample_en cycles)
// A rise is a change while level = 1; a fall is a change while level = 0.
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic sample_en,
    output logic level,
    output logic change
);

    logic [SYNC_STAGES-1:0] stage_r;
    logic                   prev_r;

    // Synchronizer chain and the history value used for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_r <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], din};
            if (sample_en) begin
                prev_r <= level;
            end
        end
    end

    assign level  = stage_r[SYNC_STAGES-1];
    assign change = sample_en & (level ^ prev_r);

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx -- I2S ADC receiver. Captures left/right words from a codec running
// on its own bit clock and presents them as a registered L/R pair.
//   Clk         : system clock (>= 8x bit clock)
//   Reset       : synchronous, active-high reset
//   AUD_BCLK    : codec bit clock (async)
//   AUD_ADCLRCK : codec word select, 0 = left, 1 = right (async)
//   AUD_ADCDAT  : codec serial data, MSB first (async)
//   Enable      : low holds the FSM in IDLE and drops partial/pending data
//   out_bus     : L_Out / R_Out / Sample_Valid / Frame_Err (master side)
// ---------------------------------------------------------------------------
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     AUD_BCLK,
    input  logic     AUD_ADCLRCK,
    input  logic     AUD_ADCDAT,
    input  logic     Enable,
    i2s_rx_if.master out_bus
);

    localparam int               CNT_W    = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

    logic bclk_level_s;
    logic bclk_change_s;
    logic bclk_rise_s;
    logic lrck_level_s;
    logic lrck_change_s;

    logic [SYNC_STAGES-1:0] dat_stage_r;
    logic                   dat_s;

    i2s_state_t          state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [SAMPLE_W-1:0] shreg_r, shreg_s;
    logic [SAMPLE_W-1:0] word_s;
    logic [SAMPLE_W-1:0] latch_r, latch_s;
    logic [SAMPLE_W-1:0] l_out_r, l_out_s;
    logic [SAMPLE_W-1:0] r_out_r, r_out_s;
    logic                chan_r, chan_s;
    logic                pend_r, pend_s;
    logic                valid_r, valid_s;
    logic                ferr_r, ferr_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk       (Clk),
        .reset     (Reset),
        .din       (AUD_BCLK),
        .sample_en (1'b1),
        .level     (bclk_level_s),
        .change    (bclk_change_s)
    );

    assign bclk_rise_s = bclk_change_s & bclk_level_s;

    // Word select is only looked at on bit-clock rises, so an edge means
    // "different from the value seen at the previous BCLK rise".
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk       (Clk),
        .reset     (Reset),
        .din       (AUD_ADCLRCK),
        .sample_en (bclk_rise_s),
        .level     (lrck_level_s),
        .change    (lrck_change_s)
    );

    // Data synchronizer, same depth as BCLK so data lines up with the rise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dat_stage_r <= {SYNC_STAGES{1'b0}};
        end else begin
            dat_stage_r <= {dat_stage_r[SYNC_STAGES-2:0], AUD_ADCDAT};
        end
    end

    assign dat_s  = dat_stage_r[SYNC_STAGES-1];
    assign word_s = {shreg_r[SAMPLE_W-2:0], dat_s};

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {SAMPLE_W{1'b0}};
            latch_r <= {SAMPLE_W{1'b0}};
            l_out_r <= {SAMPLE_W{1'b0}};
            r_out_r <= {SAMPLE_W{1'b0}};
            chan_r  <= 1'b0;
            pend_r  <= 1'b0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
            latch_r <= latch_s;
            l_out_r <= l_out_s;
            r_out_r <= r_out_s;
            chan_r  <= chan_s;
            pend_r  <= pend_s;
            valid_r <= valid_s & ~ferr_s;
            ferr_r  <= ferr_s;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shreg_s = shreg_r;
        latch_s = latch_r;
        l_out_s = l_out_r;
        r_out_s = r_out_r;
        chan_s  = chan_r;
        pend_s  = pend_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;

        if (!Enable) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            shreg_s = {SAMPLE_W{1'b0}};
            pend_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Only a falling word select (left start) opens a frame.
                    if (lrck_change_s && !lrck_level_s) begin
                        state_s = ALIGN;
                        chan_s  = 1'b0;
                        pend_s  = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ALIGN: begin
                    // The rise that flagged the word-select edge carries the
                    // I2S one-bit delay slot and is not shifted. At >= 8x
                    // oversampling no other rise can land in this cycle, so
                    // the first rise seen in SHIFT is the MSB.
                    cnt_s   = {CNT_W{1'b0}};
                    shreg_s = {SAMPLE_W{1'b0}};
                    state_s = SHIFT;
                end
                SHIFT: begin
                    if (lrck_change_s) begin
                        // Short word: drop it, and any left word it pairs with.
                        ferr_s  = 1'b1;
                        state_s = ALIGN;
                        chan_s  = lrck_level_s;
                        cnt_s   = {CNT_W{1'b0}};
                        shreg_s = {SAMPLE_W{1'b0}};
                        pend_s  = 1'b0;
                    end else if (bclk_rise_s) begin
                        shreg_s = word_s;
                        cnt_s   = cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_BIT) begin
                            state_s = HOLD;
                            if (!chan_r) begin
                                latch_s = word_s;
                                pend_s  = 1'b1;
                            end else if (pend_r) begin
                                l_out_s = latch_r;
                                r_out_s = word_s;
                                valid_s = 1'b1;
                                pend_s  = 1'b0;
                            end else begin
                                pend_s  = 1'b0;
                            end
                        end else begin
                            state_s = SHIFT;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
                HOLD: begin
                    // Trailing slot bits are ignored until the next channel.
                    if (lrck_change_s) begin
                        state_s = ALIGN;
                        chan_s  = lrck_level_s;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    pend_s  = 1'b0;
                end
            endcase
        end
    end

    assign out_bus.L_Out        = l_out_r;
    assign out_bus.R_Out        = r_out_r;
    assign out_bus.Sample_Valid = valid_r;
    assign out_bus.Frame_Err    = ferr_r;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: SAMPLE_W, default 24, audio sample width in bits.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer flops per async input (minimum 2).
REQ-003 Clk  input  1  system clock; the block's single clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 AUD_BCLK  input  1  codec bit clock, asynchronous to Clk.
REQ-006 AUD_ADCLRCK  input  1  codec word select (0 = left, 1 = right), asynchronous to Clk.
REQ-007 AUD_ADCDAT  input  1  codec serial ADC data, MSB first, asynchronous to Clk.
REQ-008 Enable  input  1  when low, capture is suppressed and the FSM is held in IDLE.
REQ-009 L_Out  output  SAMPLE_W  last complete left sample, two's complement.
REQ-010 R_Out  output  SAMPLE_W  last complete right sample, two's complement.
REQ-011 Sample_Valid  output  1  one-Clk pulse when a new L/R pair is presented.
REQ-012 Frame_Err  output  1  one-Clk pulse when a word select edge arrives before SAMPLE_W bits are captured.

Function
REQ-013 Each of AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT SHALL pass through SYNC_STAGES flops before use.
REQ-014 A BCLK rise event SHALL be flagged in the cycle where synchronized BCLK = 1 and its previous registered value = 0.
REQ-015 An LRCK edge SHALL be flagged on any change of synchronized LRCK, sampled only on BCLK rise events.
REQ-016 Clk frequency SHALL be >= 8x BCLK frequency; behaviour below this ratio is undefined.
REQ-017 FSM states: IDLE, ALIGN, SHIFT, HOLD.
REQ-018 IDLE: on an LRCK falling edge (left channel start) with Enable = 1, the FSM SHALL go to ALIGN. LRCK rising edges SHALL be ignored in IDLE.
REQ-019 ALIGN: the FSM SHALL discard exactly one BCLK rise (I2S one-bit delay), clear the bit counter and go to SHIFT.
REQ-020 SHIFT: on each BCLK rise, synchronized ADCDAT SHALL shift into the channel shift register LSB-ward (MSB first) and the counter SHALL increment. After bit SAMPLE_W the FSM SHALL go to HOLD.
REQ-021 HOLD: bits beyond SAMPLE_W SHALL be ignored. On the next LRCK edge the FSM SHALL go to ALIGN for the opposite channel.
REQ-022 A completed left word SHALL be held in an internal left latch and SHALL NOT drive L_Out yet.
REQ-023 When the SAMPLE_W-th right bit is shifted in cycle N, L_Out and R_Out SHALL update together and Sample_Valid SHALL = 1 in cycle N+1 only.
REQ-024 An LRCK edge while in SHIFT with counter < SAMPLE_W SHALL pulse Frame_Err in the following cycle and discard the partial word. The FSM SHALL go to ALIGN for the new channel. If a right word is discarded, the pending left latch SHALL also be discarded.
REQ-025 A right-channel start seen without a completed left word in the same frame SHALL produce no Sample_Valid for that frame.
REQ-026 Enable deasserted at any time SHALL return the FSM to IDLE next cycle and discard partial and pending data. L_Out and R_Out SHALL retain their values.
REQ-027 Sample_Valid and Frame_Err SHALL never both be high in the same cycle. Frame_Err takes priority and suppresses Sample_Valid.

Reset
REQ-028 While Reset = 1 at a Clk edge: FSM = IDLE; L_Out, R_Out, shift registers, latches and counter = 0; Sample_Valid = 0; Frame_Err = 0; synchronizer flops = 0.
REQ-029 Reset mid-frame SHALL abandon the frame. After release, capture SHALL begin only at the next LRCK falling edge.

Structure
REQ-030 Package audio_pkg SHALL hold SAMPLE_W, the i2s_state_t enum (IDLE, ALIGN, SHIFT, HOLD) and the sample_t typedef (logic [SAMPLE_W-1:0]).
REQ-031 Sub-module sync_edge (SYNC_STAGES synchronizer plus rise/change detect) SHALL be instantiated for BCLK and LRCK. ADCDAT SHALL use the synchronizer path only.
REQ-032 L_Out, R_Out and Sample_Valid SHALL connect directly to the downstream digital_delay D_In path via the top level.

Verification
REQ-033 Clk = 50 MHz, BCLK = 3.072 MHz, 64-bit frames; left 24'h7FFFFF, right 24'h800001 -> L_Out = 24'h7FFFFF, R_Out = 24'h800001, one Sample_Valid pulse per frame.
REQ-034 Start stimulus mid-right-channel -> no Sample_Valid until the first full frame following an LRCK falling edge.
REQ-035 Left word truncated to 20 bits by an early LRCK edge -> one Frame_Err pulse, no Sample_Valid that frame, previous L_Out/R_Out unchanged.
REQ-036 Reset asserted for 1 Clk at bit 12 of the right word -> outputs = 0, the next full frame 24'h123456/24'hABCDEF is captured correctly.
REQ-037 Enable dropped during the left word, restored 2 frames later -> no Sample_Valid while low, correct capture from the next complete frame.
REQ-038 32-bit slots with trailing bits = 1 -> those bits are ignored; 24'h000001/24'hFFFFFE are captured exactly.
